// File: rtl/ti_sbox_sequencer.sv
// Serializes one shared 4-bit TI S-box datapath over a full shared state.
// Nibbles are issued one per cycle in order. A valid-tag pipe follows each
// nibble through the external S-box, so each result is captured the moment
// it emerges. Shares are only ever routed and are never combined.
module ti_sbox_sequencer #(
  parameter int NIBBLES  = 16,
  parameter int SHARES   = 2,
  parameter int SBOX_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [4*SHARES*NIBBLES-1:0]   state_in,
  output logic                          busy,
  output logic                          done,
  output logic [4*SHARES*NIBBLES-1:0]   state_out,
  output logic                          sbox_en,
  output logic [4*SHARES-1:0]           sbox_din,
  input  logic [4*SHARES-1:0]           sbox_dout
);
  localparam int CNT_W = $clog2(NIBBLES + 1);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // share-major layout: share s of nibble k sits at ((s*NIBBLES+k)*4 +: 4)
  typedef logic [SHARES-1:0][NIBBLES-1:0][3:0] state_t;
  typedef logic [SHARES-1:0][3:0]              nib_t;

  logic [1:0]          fsm_q, fsm_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  state_t              lat_q, lat_d;
  state_t              res_q, res_d;
  state_t              out_q, out_d;
  logic [SBOX_LAT-1:0] vld_pipe_q, vld_pipe_d;

  logic [IDX_W-1:0] tx_idx, rx_idx;
  nib_t             dout_n, din_n;
  logic             capture, last_cap;

  assign tx_idx   = tx_cnt_q[IDX_W-1:0];
  assign rx_idx   = rx_cnt_q[IDX_W-1:0];
  assign dout_n   = sbox_dout;
  assign capture  = vld_pipe_q[SBOX_LAT-1];
  assign last_cap = capture && (rx_cnt_q == CNT_W'(NIBBLES - 1));

  // issue mux: the current nibble only while RUN, all-zero otherwise
  always_comb begin
    din_n = '0;
    if (fsm_q == S_RUN)
      for (int s = 0; s < SHARES; s++) din_n[s] = lat_q[s][tx_idx];
  end

  assign sbox_din  = din_n;
  assign busy      = (fsm_q == S_RUN) || (fsm_q == S_DRAIN);
  assign sbox_en   = busy;
  assign done      = (fsm_q == S_DONE);
  assign state_out = out_q;

  // next-state: FSM, counters, tag pipe, result capture
  always_comb begin
    fsm_d      = fsm_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    lat_d      = lat_q;
    res_d      = res_q;
    out_d      = out_q;
    vld_pipe_d = vld_pipe_q << 1;
    vld_pipe_d[0] = (fsm_q == S_RUN);

    // A tag that leaves the pipe marks sbox_dout as holding result[rx_cnt].
    if (capture) begin
      for (int s = 0; s < SHARES; s++) res_d[s][rx_idx] = dout_n[s];
      rx_cnt_d = rx_cnt_q + CNT_W'(1);
    end

    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          lat_d    = state_t'(state_in);
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          fsm_d    = S_RUN;
        end
      end
      S_RUN: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_cnt_q == CNT_W'(NIBBLES - 1)) fsm_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Publish with the final nibble merged in, so state_out is
        // already valid during the cycle in which done is high.
        if (last_cap) begin
          out_d = res_d;
          fsm_d = S_DONE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // state registers; reset abandons any layer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      lat_q      <= '0;
      res_q      <= '0;
      out_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      lat_q      <= lat_d;
      res_q      <= res_d;
      out_q      <= out_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end
endmodule

// File: tb/tb_ti_sbox_sequencer.sv
// Bench for ti_sbox_sequencer. It models a 2-share PRESENT S-box pipeline of
// depth LAT, gated by sbox_en. Each share pair (a, b) maps to
// (S(a^b)^b, b), so the recombined output is S(x) and each share can be
// checked bit-for-bit. Expected layers wait in a scoreboard queue until done.
module tb_ti_sbox_sequencer;
  localparam int N   = 16;
  localparam int SH  = 2;
  localparam int LAT = 2;
  localparam int W   = 4*SH*N;
  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   state_in;
  logic           busy, done, sbox_en;
  logic [W-1:0]   state_out;
  logic [4*SH-1:0] sbox_din, sbox_dout;

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;
  logic [W-1:0] sb_q[$];
  int           done_times[$];
  logic [W-1:0] last_out;
  logic [7:0]   dp_pipe [LAT];

  ti_sbox_sequencer #(.NIBBLES(N), .SHARES(SH), .SBOX_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in),
    .busy(busy), .done(done), .state_out(state_out),
    .sbox_en(sbox_en), .sbox_din(sbox_din), .sbox_dout(sbox_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic logic [7:0] dp_f(input logic [7:0] d);
    logic [3:0] a, b;
    a = d[3:0];
    b = d[7:4];
    return {b, SB[a ^ b] ^ b};
  endfunction

  // external datapath: LAT enabled register stages
  always @(posedge clk) begin
    if (sbox_en) begin
      dp_pipe[0] <= dp_f(sbox_din);
      for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  end
  assign sbox_dout = dp_pipe[LAT-1];

  function automatic logic [W-1:0] model(input logic [W-1:0] st);
    logic [W-1:0] r;
    logic [3:0] a, b;
    r = '0;
    for (int k = 0; k < N; k++) begin
      a = st[4*k +: 4];
      b = st[4*N + 4*k +: 4];
      r[4*k +: 4]       = SB[a ^ b] ^ b;
      r[4*N + 4*k +: 4] = b;
    end
    return r;
  endfunction

  function automatic logic [7:0] nib(input logic [W-1:0] st, input int k);
    return {st[4*N + 4*k +: 4], st[4*k +: 4]};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every done pops one expected layer
  always @(negedge clk) begin
    if (done) begin
      done_times.push_back(gcyc);
      last_out = state_out;
      if (sb_q.size() == 0) check("done_unexpected", 1, 0);
      else check("state_out", state_out, sb_q.pop_front());
    end
  end

  // one layer with per-cycle checks of issue order, enables and done latency
  task automatic run_layer(input logic [W-1:0] st);
    int  cyc;
    bit  seen;
    logic [7:0] exp_din;
    @(negedge clk);
    state_in = st;
    start    = 1'b1;
    sb_q.push_back(model(st));
    @(posedge clk);
    #1;
    start    = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    cyc  = 0;
    seen = 0;
    while (!seen && cyc <= N + LAT + 4) begin
      @(negedge clk);
      exp_din = (cyc < N) ? nib(st, cyc) : 8'h00;
      check($sformatf("sbox_din@%0d", cyc), W'(sbox_din), W'(exp_din));
      check($sformatf("sbox_en@%0d", cyc), W'(sbox_en), W'(cyc < N + LAT));
      check($sformatf("busy@%0d", cyc), W'(busy), W'(cyc < N + LAT));
      if (done) seen = 1;
      else cyc++;
    end
    check("done_latency", W'(cyc), W'(N + LAT));
  endtask

  initial begin
    logic [W-1:0] st;
    logic [63:0]  m;
    int           nd;
    rst      = 1'b1;
    start    = 1'b0;
    state_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_en", W'(sbox_en), 0);
    check("rst_din", W'(sbox_din), 0);
    check("rst_state_out", state_out, 0);
    rst = 1'b0;

    // all-zero state, share1 = 0
    run_layer('0);
    @(negedge clk);
    check("zero_recombined", W'(last_out[63:0] ^ last_out[127:64]), W'(64'hCCCC_CCCC_CCCC_CCCC));

    // random shares of a counting state
    m  = {$urandom, $urandom};
    st = {m, 64'h0123_4567_89AB_CDEF ^ m};
    run_layer(st);
    @(negedge clk);
    check("count_recombined", W'(last_out[63:0] ^ last_out[127:64]), W'(64'hC56B_90AD_3EF8_4712));

    // back-to-back layers: start taken the cycle after done
    run_layer({$urandom, $urandom, $urandom, $urandom});
    run_layer({$urandom, $urandom, $urandom, $urandom});

    // start held high for 40 cycles gives exactly two layers, 20 cycles apart
    repeat (3) @(negedge clk);
    nd = done_times.size();
    st = {$urandom, $urandom, $urandom, $urandom};
    state_in = st;
    start    = 1'b1;
    sb_q.push_back(model(st));
    sb_q.push_back(model(st));
    repeat (40) @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("held_start_layers", W'(done_times.size() - nd), W'(2));
    if (done_times.size() - nd == 2)
      check("held_start_spacing", W'(done_times[nd+1] - done_times[nd]), W'(N + LAT + 2));

    // reset mid-layer abandons it with no done
    @(negedge clk);
    state_in = {$urandom, $urandom, $urandom, $urandom};
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", W'(busy), 0);
    check("midrst_done", W'(done), 0);
    check("midrst_state_out", state_out, 0);
    check("midrst_en", W'(sbox_en), 0);
    check("midrst_din", W'(sbox_din), 0);
    nd = done_times.size();
    repeat (25) @(negedge clk);
    check("midrst_no_done", W'(done_times.size() - nd), 0);
    run_layer({$urandom, $urandom, $urandom, $urandom});

    repeat (4) @(negedge clk);
    check("scoreboard_empty", W'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
